// File: rtl/function_accumulator_if.sv
// function_accumulator_if
//
// Bundles the command port (processor side) and the evaluator/adder
// handshakes of function_accumulator into one interface.
//
// Optional macro: FUNCTION_ACCUMULATOR_COUNT_EN adds the 16-bit op_count output.
//
// Signals (directions seen from the accumulator, i.e. the slave modport):
//   clk_en, start, n, x, lane_en   in   command strobe, opcode, operands, lane mask
//   result, done                   out  command result and one-cycle completion pulse
//   eval_start, eval_x             out  evaluator launch pulse and latched operands
//   eval_done, eval_y              in   evaluator results valid / lane results
//   add_start, add_a, add_b        out  adder launch pulse and operands
//   add_done, add_result           in   adder result valid / sum
//   op_count                       out  lane results accumulated (macro only)
//
// The master modport is the environment: processor plus evaluator plus adder.

interface function_accumulator_if #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int LANES          = 3,
  parameter int N_WIDTH        = 2
);

  logic                            clk_en;
  logic                            start;
  logic [N_WIDTH-1:0]              n;
  logic [LANES*FLT_DATA_WIDTH-1:0] x;
  logic [LANES-1:0]                lane_en;
  logic [FLT_DATA_WIDTH-1:0]       result;
  logic                            done;

  logic                            eval_start;
  logic [LANES*FLT_DATA_WIDTH-1:0] eval_x;
  logic                            eval_done;
  logic [LANES*FLT_DATA_WIDTH-1:0] eval_y;

  logic                            add_start;
  logic [FLT_DATA_WIDTH-1:0]       add_a;
  logic [FLT_DATA_WIDTH-1:0]       add_b;
  logic                            add_done;
  logic [FLT_DATA_WIDTH-1:0]       add_result;

`ifdef FUNCTION_ACCUMULATOR_COUNT_EN
  logic [15:0]                     op_count;
`endif

  modport slave (
    input  clk_en, start, n, x, lane_en, eval_done, eval_y, add_done, add_result,
`ifdef FUNCTION_ACCUMULATOR_COUNT_EN
    output op_count,
`endif
    output result, done, eval_start, eval_x, add_start, add_a, add_b
  );

  modport master (
    output clk_en, start, n, x, lane_en, eval_done, eval_y, add_done, add_result,
`ifdef FUNCTION_ACCUMULATOR_COUNT_EN
    input  op_count,
`endif
    input  result, done, eval_start, eval_x, add_start, add_a, add_b
  );

endinterface

// File: rtl/function_accumulator.sv
// function_accumulator
//
// Custom-instruction front end that hands up to LANES float operands to an
// external evaluator, then folds the selected lane results into a persistent
// running sum through an external shared FP adder. Commands: CLEAR (0),
// GO (1), READ (2), NOP (3).
//
// Optional macro: FUNCTION_ACCUMULATOR_COUNT_EN adds op_count, a saturating
// count of lane results accumulated since the last CLEAR/reset.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous, active-low reset
//   bus   function_accumulator_if.slave: command port, evaluator handshake
//         (eval_start/eval_x/eval_done/eval_y), adder handshake
//         (add_start/add_a/add_b/add_done/add_result), result/done.

module function_accumulator #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int LANES          = 3,
  parameter int IDX_WIDTH      = 2,
  parameter int N_WIDTH        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  function_accumulator_if.slave bus
);

  localparam logic [N_WIDTH-1:0] CMD_CLEAR = N_WIDTH'(0);
  localparam logic [N_WIDTH-1:0] CMD_GO    = N_WIDTH'(1);
  localparam logic [N_WIDTH-1:0] CMD_READ  = N_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE,
    EVAL,
    ACCUM,
    WAIT_ADD,
    DONE
  } state_t;

  state_t                          state;
  logic [FLT_DATA_WIDTH-1:0]       sum_q;
  logic [FLT_DATA_WIDTH-1:0]       result_q;
  logic                            done_q;
  logic                            load_result_q;
  logic                            eval_start_q;
  logic [LANES*FLT_DATA_WIDTH-1:0] eval_x_q;
  logic [LANES-1:0]                lane_en_q;
  logic [FLT_DATA_WIDTH-1:0]       lane_buf [LANES];
  logic [IDX_WIDTH-1:0]            lane_idx;
  logic [IDX_WIDTH-1:0]            cur_lane;
  logic                            add_start_q;
  logic [FLT_DATA_WIDTH-1:0]       add_a_q;
  logic [FLT_DATA_WIDTH-1:0]       add_b_q;

  logic                            start_accept;
  logic                            add_accept;
  logic                            found;
  logic [IDX_WIDTH-1:0]            sel;

  assign start_accept = (state == IDLE) && bus.start && bus.clk_en;
  assign add_accept   = (state == WAIT_ADD) && bus.add_done;

  // Lowest enabled lane at or above lane_idx. Scanning downward lets the
  // last hit win, which is the lowest index, so lanes are summed in
  // ascending order and results are reproducible.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_en_q[i] && (IDX_WIDTH'(i) >= lane_idx)) begin
        found = 1'b1;
        sel   = IDX_WIDTH'(i);
      end
    end
  end

  // Main controller. The DONE state publishes done and result together on
  // the same edge; load_result_q remembers whether the finishing command
  // copies the sum into result (everything except NOP).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      sum_q         <= '0;
      result_q      <= '0;
      done_q        <= 1'b0;
      load_result_q <= 1'b0;
      eval_start_q  <= 1'b0;
      eval_x_q      <= '0;
      lane_en_q     <= '0;
      lane_idx      <= '0;
      cur_lane      <= '0;
      add_start_q   <= 1'b0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      eval_start_q <= 1'b0;
      add_start_q  <= 1'b0;
      done_q       <= 1'b0;

      case (state)
        IDLE: begin
          if (start_accept) begin
            case (bus.n)
              CMD_CLEAR: begin
                sum_q         <= '0;
                load_result_q <= 1'b1;
                state         <= DONE;
              end
              CMD_READ: begin
                load_result_q <= 1'b1;
                state         <= DONE;
              end
              CMD_GO: begin
                eval_x_q      <= bus.x;
                lane_en_q     <= bus.lane_en;
                eval_start_q  <= 1'b1;
                load_result_q <= 1'b1;
                state         <= EVAL;
              end
              default: begin
                load_result_q <= 1'b0;
                state         <= DONE;
              end
            endcase
          end
        end

        EVAL: begin
          if (bus.eval_done) begin
            for (int i = 0; i < LANES; i++) begin
              lane_buf[i] <= bus.eval_y[i*FLT_DATA_WIDTH +: FLT_DATA_WIDTH];
            end
            lane_idx <= '0;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (found) begin
            add_a_q     <= sum_q;
            add_b_q     <= lane_buf[sel];
            add_start_q <= 1'b1;
            cur_lane    <= sel;
            state       <= WAIT_ADD;
          end else begin
            state <= DONE;
          end
        end

        WAIT_ADD: begin
          if (add_accept) begin
            sum_q    <= bus.add_result;
            lane_idx <= cur_lane + IDX_WIDTH'(1);
            state    <= ACCUM;
          end
        end

        DONE: begin
          done_q <= 1'b1;
          if (load_result_q) begin
            result_q <= sum_q;
          end
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result     = result_q;
  assign bus.done       = done_q;
  assign bus.eval_start = eval_start_q;
  assign bus.eval_x     = eval_x_q;
  assign bus.add_start  = add_start_q;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;

`ifdef FUNCTION_ACCUMULATOR_COUNT_EN
  logic        clear_accept;
  logic [15:0] op_count_q;

  assign clear_accept = start_accept && (bus.n == CMD_CLEAR);

  // Saturating count of lane results folded into the sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_count_q <= '0;
    end else if (clear_accept) begin
      op_count_q <= '0;
    end else if (add_accept && (op_count_q != 16'hFFFF)) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign bus.op_count = op_count_q;
`else
  // Counter disabled: no op_count port or state.
`endif

endmodule

// File: tb/tb_function_accumulator.sv
// tb_function_accumulator
//
// Self-checking bench for function_accumulator. Provides an identity
// evaluator (eval_done sampled 3 edges after eval_start is seen) and a
// behavioural adder (add_done sampled 2 edges after the add_start cycle).
// Operands are small non-negative integers encoded as IEEE-754 singles so
// the expected sums are exact.

`timescale 1ns/1ps

module tb_function_accumulator;

  localparam int W         = 32;
  localparam int LANES     = 3;
  localparam int IDX_WIDTH = 2;
  localparam int N_WIDTH   = 2;
  localparam int EVAL_LAT  = 3;
  localparam int ADD_LAT   = 2;

  localparam logic [N_WIDTH-1:0] CMD_CLEAR = 2'd0;
  localparam logic [N_WIDTH-1:0] CMD_GO    = 2'd1;
  localparam logic [N_WIDTH-1:0] CMD_READ  = 2'd2;
  localparam logic [N_WIDTH-1:0] CMD_NOP   = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  function_accumulator_if #(.FLT_DATA_WIDTH(W), .LANES(LANES), .N_WIDTH(N_WIDTH)) bus ();

  function_accumulator #(
    .FLT_DATA_WIDTH(W),
    .LANES(LANES),
    .IDX_WIDTH(IDX_WIDTH),
    .N_WIDTH(N_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int unsigned model_sum    = 0;
  logic [W-1:0] model_result = '0;
  int unsigned model_ops    = 0;

  int eval_start_cnt = 0;
  int done_cnt       = 0;
  logic [W-1:0] add_a_log [$];
  logic [W-1:0] add_b_log [$];
  int ecnt = 0;

  // Small non-negative integer <-> single-precision encoding (v < 2^24).
  function automatic logic [W-1:0] int2float(input int unsigned v);
    int p;
    logic [31:0] m;
    if (v == 0) return '0;
    p = 0;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) p = i;
    end
    m = (v << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int unsigned float2int(input logic [W-1:0] f);
    int e;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    return (32'({1'b1, f[22:0]})) >> (150 - e);
  endfunction

  function automatic logic [LANES*W-1:0] packX(input int unsigned a2, input int unsigned a1,
                                               input int unsigned a0);
    return {int2float(a2), int2float(a1), int2float(a0)};
  endfunction

  // Identity evaluator.
  always @(posedge clk) begin
    bus.eval_done <= 1'b0;
    if (bus.eval_start === 1'b1) begin
      bus.eval_y <= bus.eval_x;
      ecnt       <= EVAL_LAT - 1;
    end else if (ecnt != 0) begin
      ecnt <= ecnt - 1;
      if (ecnt == 1) bus.eval_done <= 1'b1;
    end
  end

  // Behavioural adder: result valid in the cycle after add_start is seen.
  always @(posedge clk) begin
    bus.add_done <= 1'b0;
    if (bus.add_start === 1'b1) begin
      bus.add_result <= int2float(float2int(bus.add_a) + float2int(bus.add_b));
      bus.add_done   <= 1'b1;
    end
  end

  // Monitor of DUT strobes.
  always @(posedge clk) begin
    if (bus.eval_start === 1'b1) eval_start_cnt <= eval_start_cnt + 1;
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.add_start === 1'b1) begin
      add_a_log.push_back(bus.add_a);
      add_b_log.push_back(bus.add_b);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_WIDTH-1:0] cmd, input logic [LANES*W-1:0] xv,
                               input logic [LANES-1:0] en);
    bus.n       = cmd;
    bus.x       = xv;
    bus.lane_en = en;
    bus.clk_en  = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic runCommand(input logic [N_WIDTH-1:0] cmd, input logic [LANES*W-1:0] xv,
                            input logic [LANES-1:0] en, input bit noisy, input string tag);
    int unsigned partial;
    int m, lat, exp_lat, base_add, base_eval, base_done;
    bit seen;
    logic [W-1:0] exp_a [$];
    logic [W-1:0] exp_b [$];

    m       = 0;
    partial = model_sum;
    if (cmd == CMD_GO) begin
      for (int i = 0; i < LANES; i++) begin
        if (en[i]) begin
          exp_a.push_back(int2float(partial));
          exp_b.push_back(xv[i*W +: W]);
          partial += float2int(xv[i*W +: W]);
          m++;
        end
      end
    end
    case (cmd)
      CMD_CLEAR: begin
        model_sum    = 0;
        model_result = '0;
        model_ops    = 0;
      end
      CMD_READ: model_result = int2float(model_sum);
      CMD_GO: begin
        model_sum    = partial;
        model_result = int2float(model_sum);
        model_ops    = (model_ops + m > 65535) ? 65535 : model_ops + m;
      end
      default: ;
    endcase
    exp_lat = (cmd == CMD_GO) ? (1 + EVAL_LAT + 1 + m * (ADD_LAT + 1) + 1) : 1;

    base_add  = add_b_log.size();
    base_eval = eval_start_cnt;
    base_done = done_cnt;

    applyStimulus(cmd, xv, en);
    if (noisy) begin
      bus.n     = CMD_CLEAR;
      bus.start = 1'b1;
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat >= 4) bus.start = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
    end

    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_result"}, bus.result, model_result);
    checkOutput({tag, "_eval_starts"}, 32'(eval_start_cnt - base_eval),
                (cmd == CMD_GO) ? 32'd1 : 32'd0);
    checkOutput({tag, "_add_starts"}, 32'(add_b_log.size() - base_add), 32'(m));
    for (int j = 0; j < m; j++) begin
      if (base_add + j < add_b_log.size()) begin
        checkOutput($sformatf("%s_add_a%0d", tag, j), add_a_log[base_add + j], exp_a[j]);
        checkOutput($sformatf("%s_add_b%0d", tag, j), add_b_log[base_add + j], exp_b[j]);
      end
    end
    if (cmd == CMD_GO) begin
      checkOutput({tag, "_eval_x_lane0"}, bus.eval_x[0 +: W], xv[0 +: W]);
      checkOutput({tag, "_eval_x_lane2"}, bus.eval_x[2*W +: W], xv[2*W +: W]);
    end
`ifdef FUNCTION_ACCUMULATOR_COUNT_EN
    checkOutput({tag, "_op_count"}, 32'(bus.op_count), model_ops);
`endif

    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse_end"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "_result_hold"}, bus.result, model_result);
    checkOutput({tag, "_done_count"}, 32'(done_cnt - base_done), 32'd1);
  endtask

  initial begin
    logic [LANES*W-1:0] x321;
    logic [LANES*W-1:0] xr;
    int base_done, base_eval, r;
    bit got;

    bus.clk_en  = 1'b0;
    bus.start   = 1'b0;
    bus.n       = CMD_NOP;
    bus.x       = '0;
    bus.lane_en = '0;
    x321        = packX(3, 2, 1);

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_result", bus.result, 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_eval_x", bus.eval_x[W-1:0], 32'h0);
    checkOutput("reset_add_b", bus.add_b, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] read after reset");
    runCommand(CMD_READ, x321, 3'b111, 1'b0, "read0");
    checkOutput("read0_const", bus.result, 32'h0000_0000);
    checkOutput("no_strobes_yet", 32'(eval_start_cnt + add_b_log.size()), 32'd0);

    $display("[TB] directed accumulation");
    runCommand(CMD_GO, x321, 3'b111, 1'b0, "go1");
    checkOutput("go1_const", bus.result, 32'h40C0_0000);
    runCommand(CMD_GO, x321, 3'b111, 1'b0, "go2");
    checkOutput("go2_const", bus.result, 32'h4140_0000);
    runCommand(CMD_CLEAR, x321, 3'b000, 1'b0, "clear1");
    checkOutput("clear1_const", bus.result, 32'h0);
    runCommand(CMD_GO, x321, 3'b101, 1'b0, "go101");
    checkOutput("go101_const", bus.result, 32'h4080_0000);
    runCommand(CMD_GO, x321, 3'b000, 1'b0, "go000");
    checkOutput("go000_const", bus.result, 32'h4080_0000);
    runCommand(CMD_NOP, x321, 3'b000, 1'b0, "nop1");
    runCommand(CMD_CLEAR, x321, 3'b000, 1'b0, "clear2");
    runCommand(CMD_READ, x321, 3'b000, 1'b0, "read1");
    checkOutput("read1_const", bus.result, 32'h0);

    $display("[TB] start gated by clk_en");
    base_done   = done_cnt;
    base_eval   = eval_start_cnt;
    bus.n       = CMD_GO;
    bus.x       = x321;
    bus.lane_en = 3'b111;
    bus.clk_en  = 1'b0;
    bus.start   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("clk_en0_no_done", 32'(done_cnt - base_done), 32'd0);
    checkOutput("clk_en0_no_eval", 32'(eval_start_cnt - base_eval), 32'd0);

    $display("[TB] start while busy");
    runCommand(CMD_GO, x321, 3'b111, 1'b1, "busy_go");
    checkOutput("busy_go_const", bus.result, 32'h40C0_0000);
    runCommand(CMD_READ, x321, 3'b000, 1'b0, "busy_read");

    $display("[TB] randomized commands");
    for (int it = 0; it < 10; it++) begin
      r  = int'($urandom_range(0, 9));
      xr = packX($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      if (r == 6)
        runCommand(CMD_READ, xr, 3'($urandom_range(0, 7)), 1'b0, $sformatf("rnd%0d_read", it));
      else if (r == 7)
        runCommand(CMD_CLEAR, xr, 3'($urandom_range(0, 7)), 1'b0, $sformatf("rnd%0d_clear", it));
      else if (r == 8)
        runCommand(CMD_NOP, xr, 3'($urandom_range(0, 7)), 1'b0, $sformatf("rnd%0d_nop", it));
      else
        runCommand(CMD_GO, xr, 3'($urandom_range(0, 7)), 1'b0, $sformatf("rnd%0d_go", it));
    end

    $display("[TB] reset during WAIT_ADD");
    applyStimulus(CMD_GO, x321, 3'b111);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clk);
      #1;
      if (bus.add_start === 1'b1) got = 1'b1;
    end
    checkOutput("midrst_reached_add", 32'(got), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_result", bus.result, 32'h0);
    checkOutput("midrst_done", 32'(bus.done), 32'd0);
    checkOutput("midrst_eval_start", 32'(bus.eval_start), 32'd0);
    checkOutput("midrst_add_start", 32'(bus.add_start), 32'd0);
    checkOutput("midrst_eval_x", bus.eval_x[W-1:0], 32'h0);
    checkOutput("midrst_add_a", bus.add_a, 32'h0);
    checkOutput("midrst_add_b", bus.add_b, 32'h0);
    rst          = 1'b1;
    model_sum    = 0;
    model_result = '0;
    model_ops    = 0;
    base_done    = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrst_late_add_ignored", 32'(done_cnt - base_done), 32'd0);
    runCommand(CMD_READ, x321, 3'b000, 1'b0, "midrst_read");
    checkOutput("midrst_read_const", bus.result, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
